// File: rtl/camera_capture.sv
// Camera byte-stream capture into RGB332 frame-buffer writes.
// Camera inputs are synchronized to CLK; PCLK rising edges are detected in the CLK domain.
module camera_capture #(
    parameter int IMG_WIDTH   = 176,
    parameter int IMG_HEIGHT  = 144,
    parameter int ADDR_W      = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic              SINGLE_SHOT,
    input  logic              FORMAT,
    input  logic [7:0]        CAM_DATA,
    input  logic              CAM_PCLK,
    input  logic              CAM_HREF,
    input  logic              CAM_VSYNC,
    output logic [7:0]        PIXEL_OUT,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic              W_EN,
    output logic              FRAME_DONE,
    output logic              OVERFLOW,
    output logic              BUSY
);

    localparam int COL_W = $clog2(IMG_WIDTH + 1);
    localparam int ROW_W = $clog2(IMG_HEIGHT + 1);
    localparam logic [COL_W-1:0]  COL_LIM = COL_W'(IMG_WIDTH);
    localparam logic [ROW_W-1:0]  ROW_LIM = ROW_W'(IMG_HEIGHT);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VS,
        S_FRAME
    } state_t;

    // One shared chain keeps VSYNC, HREF, PCLK and DATA cycle-aligned.
    logic [SYNC_STAGES-1:0][10:0] r_sync;
    logic [10:0]        w_cam;
    logic               w_vs;
    logic               w_href;
    logic               w_pclk;
    logic [7:0]         w_data;
    logic               w_sample;
    logic [7:0]         w_pix;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_in_win;

    state_t             r_state;
    logic               r_pclk_d;
    logic               r_vs_prev;
    logic               r_href_prev;
    logic               r_fmt;
    logic               r_single;
    logic               r_hold;
    logic               r_phase;
    logic [7:0]         r_byte0;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [ADDR_W-1:0]  r_line_base;

    assign w_cam    = {CAM_VSYNC, CAM_HREF, CAM_PCLK, CAM_DATA};
    assign w_vs     = r_sync[SYNC_STAGES-1][10];
    assign w_href   = r_sync[SYNC_STAGES-1][9];
    assign w_pclk   = r_sync[SYNC_STAGES-1][8];
    assign w_data   = r_sync[SYNC_STAGES-1][7:0];
    assign w_sample = w_pclk & ~r_pclk_d;
    assign w_addr   = r_line_base + ADDR_W'(r_col);
    assign w_in_win = (r_col < COL_LIM) && (r_row < ROW_LIM);
    assign w_pix    = r_fmt ? {r_byte0[3:1], w_data[7:5], w_data[3:2]}
                            : {r_byte0[7:5], r_byte0[2:0], w_data[4:3]};
    assign BUSY     = (r_state != S_IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_cam};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_pclk_d    <= 1'b0;
            r_vs_prev   <= 1'b0;
            r_href_prev <= 1'b0;
            r_fmt       <= 1'b0;
            r_single    <= 1'b0;
            r_hold      <= 1'b0;
            r_phase     <= 1'b0;
            r_byte0     <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_line_base <= '0;
            PIXEL_OUT   <= '0;
            W_ADDR      <= '0;
            W_EN        <= 1'b0;
            FRAME_DONE  <= 1'b0;
            OVERFLOW    <= 1'b0;
        end else begin
            r_pclk_d   <= w_pclk;
            W_EN       <= 1'b0;
            FRAME_DONE <= 1'b0;
            if (w_sample) begin
                r_vs_prev   <= w_vs;
                r_href_prev <= w_href;
            end
            // A single-shot disarm holds until ENABLE is dropped.
            if (!ENABLE) begin
                r_hold <= 1'b0;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (ENABLE && !r_hold) begin
                        r_state  <= S_WAIT_VS;
                        r_fmt    <= FORMAT;
                        r_single <= SINGLE_SHOT;
                    end
                end
                S_WAIT_VS: begin
                    if (w_sample && r_vs_prev && !w_vs) begin
                        r_state     <= S_FRAME;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_phase     <= 1'b0;
                        r_line_base <= '0;
                        OVERFLOW    <= 1'b0;
                    end
                end
                S_FRAME: begin
                    if (w_sample) begin
                        if (w_vs) begin
                            FRAME_DONE <= 1'b1;
                            r_phase    <= 1'b0;
                            if (r_single || !ENABLE) begin
                                r_state <= S_IDLE;
                                r_hold  <= r_single;
                            end else begin
                                r_state  <= S_WAIT_VS;
                                r_fmt    <= FORMAT;
                                r_single <= SINGLE_SHOT;
                            end
                        end else if (w_href) begin
                            if (!r_phase) begin
                                r_byte0 <= w_data;
                                r_phase <= 1'b1;
                            end else begin
                                r_phase <= 1'b0;
                                if (w_in_win) begin
                                    W_EN      <= 1'b1;
                                    PIXEL_OUT <= w_pix;
                                    W_ADDR    <= w_addr;
                                    r_col     <= r_col + 1'b1;
                                end else begin
                                    OVERFLOW <= 1'b1;
                                end
                            end
                        end else begin
                            r_phase <= 1'b0;
                            if (r_href_prev) begin
                                r_col <= '0;
                                if (r_col != '0 && r_row < ROW_LIM) begin
                                    r_row       <= r_row + 1'b1;
                                    r_line_base <= r_line_base + LINE_STEP;
                                end
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture on a reduced 8x6 image.
// A table of format vectors plus hand-written multi-frame sequences.
module tb_camera_capture;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int AW = 6;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          ENABLE = 1'b0;
    logic          SINGLE_SHOT = 1'b0;
    logic          FORMAT = 1'b0;
    logic [7:0]    CAM_DATA = '0;
    logic          CAM_PCLK = 1'b0;
    logic          CAM_HREF = 1'b0;
    logic          CAM_VSYNC = 1'b0;
    logic [7:0]    PIXEL_OUT;
    logic [AW-1:0] W_ADDR;
    logic          W_EN;
    logic          FRAME_DONE;
    logic          OVERFLOW;
    logic          BUSY;

    camera_capture #(
        .IMG_WIDTH(W),
        .IMG_HEIGHT(H),
        .ADDR_W(AW),
        .SYNC_STAGES(2)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .ENABLE(ENABLE),
        .SINGLE_SHOT(SINGLE_SHOT),
        .FORMAT(FORMAT),
        .CAM_DATA(CAM_DATA),
        .CAM_PCLK(CAM_PCLK),
        .CAM_HREF(CAM_HREF),
        .CAM_VSYNC(CAM_VSYNC),
        .PIXEL_OUT(PIXEL_OUT),
        .W_ADDR(W_ADDR),
        .W_EN(W_EN),
        .FRAME_DONE(FRAME_DONE),
        .OVERFLOW(OVERFLOW),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       fmt;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] exp_pix;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    int         mon_wen = 0;
    int         mon_fd = 0;
    int         mon_seq = 0;
    int         mon_max = 0;
    int         mon_last = -1;
    logic [7:0] mon_pix = '0;
    logic       mon_ovf = 1'b0;

    int b_wen;
    int b_fd;
    int b_seq;

    always @(negedge CLK) begin
        if (W_EN) begin
            if (W_ADDR != '0 && int'(W_ADDR) != mon_last + 1) mon_seq++;
            mon_last = int'(W_ADDR);
            if (mon_last > mon_max) mon_max = mon_last;
            mon_pix = PIXEL_OUT;
            mon_wen++;
        end
        if (FRAME_DONE) begin
            mon_fd++;
            mon_ovf = OVERFLOW;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                      name, act, act, exp, exp);
    endtask

    task automatic snap();
        b_wen = mon_wen;
        b_fd  = mon_fd;
        b_seq = mon_seq;
    endtask

    task automatic tick(input logic vs, input logic hr, input logic [7:0] d);
        CAM_VSYNC = vs;
        CAM_HREF  = hr;
        CAM_DATA  = d;
        #20 CAM_PCLK = 1'b1;
        #20 CAM_PCLK = 1'b0;
    endtask

    task automatic frame_start();
        repeat (3) tick(1'b1, 1'b0, 8'h00);
        repeat (2) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_lines(input int n, input int pix,
                              input logic [7:0] b0, input logic [7:0] b1);
        for (int l = 0; l < n; l++) begin
            for (int p = 0; p < pix; p++) begin
                tick(1'b0, 1'b1, b0);
                tick(1'b0, 1'b1, b1);
            end
            repeat (2) tick(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic frame_end();
        repeat (3) tick(1'b1, 1'b0, 8'h00);
        repeat (4) @(posedge CLK);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b0, 8'hF8, 8'h1F, 8'hE3};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{1'b0, 8'hA5, 8'h5A, 8'hB7};
        vecs[3] = '{1'b0, 8'h07, 8'h18, 8'h1F};
        vecs[4] = '{1'b1, 8'h0F, 8'hFF, 8'hFF};
        vecs[5] = '{1'b1, 8'h08, 8'h40, 8'h88};
        vecs[6] = '{1'b1, 8'hF3, 8'hA6, 8'h35};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_wen", W_EN, 0);
        check("rst_busy", BUSY, 0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_pix", PIXEL_OUT, 0);
        check("rst_addr", W_ADDR, 0);
        check("rst_fd", FRAME_DONE, 0);
        check("rst_ovf", OVERFLOW, 0);
        check("rst_busy_rel", BUSY, 0);

        // Full RGB565 frame, stays armed afterwards.
        ENABLE = 1'b1;
        repeat (3) @(posedge CLK);
        check("arm_busy", BUSY, 1);
        snap();
        frame_start();
        send_lines(H, W, 8'hF8, 8'h1F);
        frame_end();
        check("full_wen", mon_wen - b_wen, W * H);
        check("full_pix", mon_pix, 8'hE3);
        check("full_last", mon_last, W * H - 1);
        check("full_fd", mon_fd - b_fd, 1);
        check("full_ovf", mon_ovf, 0);
        check("full_seq", mon_seq - b_seq, 0);
        check("full_busy", BUSY, 1);

        @(negedge CLK) RESET = 1'b1;
        ENABLE = 1'b0;
        @(negedge CLK) RESET = 1'b0;

        // Format table: arm, then drop ENABLE so each frame ends in idle.
        for (int i = 0; i < 7; i++) begin
            FORMAT = vecs[i].fmt;
            ENABLE = 1'b1;
            repeat (3) @(posedge CLK);
            ENABLE = 1'b0;
            snap();
            frame_start();
            send_lines(1, 2, vecs[i].b0, vecs[i].b1);
            frame_end();
            check($sformatf("vec%0d_wen", i), mon_wen - b_wen, 2);
            check($sformatf("vec%0d_pix", i), mon_pix, vecs[i].exp_pix);
        end
        check("vec_idle", BUSY, 0);

        // Oversized frame: 10 pixels x 8 lines into an 8x6 window.
        FORMAT = 1'b0;
        ENABLE = 1'b1;
        repeat (3) @(posedge CLK);
        ENABLE = 1'b0;
        snap();
        frame_start();
        send_lines(H + 2, W + 2, 8'hF8, 8'h1F);
        frame_end();
        check("ovf_wen", mon_wen - b_wen, W * H);
        check("ovf_last", mon_last, W * H - 1);
        check("ovf_max", mon_max, W * H - 1);
        check("ovf_at_fd", mon_ovf, 1);
        check("ovf_sticky", OVERFLOW, 1);
        check("ovf_seq", mon_seq - b_seq, 0);

        // Single shot with ENABLE held: three frames, one capture.
        SINGLE_SHOT = 1'b1;
        ENABLE = 1'b1;
        repeat (3) @(posedge CLK);
        snap();
        for (int f = 0; f < 3; f++) begin
            frame_start();
            send_lines(H, W, 8'h0F, 8'hFF);
            frame_end();
        end
        check("ss_fd", mon_fd - b_fd, 1);
        check("ss_wen", mon_wen - b_wen, W * H);
        check("ss_busy", BUSY, 0);
        check("ss_ovf_clr", OVERFLOW, 0);
        ENABLE = 1'b0;
        SINGLE_SHOT = 1'b0;
        repeat (3) @(posedge CLK);

        // Arming mid-frame skips that frame, captures the next.
        snap();
        frame_start();
        send_lines(2, W, 8'hF8, 8'h1F);
        ENABLE = 1'b1;
        repeat (4) @(posedge CLK);
        send_lines(H - 2, W, 8'hF8, 8'h1F);
        frame_end();
        check("mid_wen", mon_wen - b_wen, 0);
        check("mid_fd", mon_fd - b_fd, 0);
        snap();
        frame_start();
        send_lines(H, W, 8'hA5, 8'h5A);
        frame_end();
        check("next_wen", mon_wen - b_wen, W * H);
        check("next_pix", mon_pix, 8'hB7);
        check("next_fd", mon_fd - b_fd, 1);

        // Reset in the middle of a frame.
        frame_start();
        send_lines(3, W, 8'hF8, 8'h1F);
        check("pre_rst_addr", W_ADDR, 3 * W - 1);
        @(negedge CLK) RESET = 1'b1;
        #1;
        check("mrst_addr", W_ADDR, 0);
        check("mrst_pix", PIXEL_OUT, 0);
        check("mrst_busy", BUSY, 0);
        @(negedge CLK) RESET = 1'b0;
        snap();
        send_lines(H - 3, W, 8'hF8, 8'h1F);
        frame_end();
        check("post_rst_wen", mon_wen - b_wen, 0);
        check("post_rst_fd", mon_fd - b_fd, 0);
        snap();
        frame_start();
        send_lines(H, W, 8'hF8, 8'h1F);
        frame_end();
        check("rec_wen", mon_wen - b_wen, W * H);
        check("rec_last", mon_last, W * H - 1);
        check("rec_seq", mon_seq - b_seq, 0);
        check("rec_fd", mon_fd - b_fd, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
